glyph_fetch_sched: RTL and testbench
====================================

// Module: glyph_fetch_sched
// PURPOSE
// - Sequences the 2Kx8 character glyph ROM (1-cycle registered read) for the 80x60 8x8 text-mode VGA renderer.
// - Per char cell: reads text RAM code -> issues ROM addr {code,glyph_row} -> loads 8-bit shifter -> serial pixel out.
// - Shares the ROM with a host requester (font readback/debug); renderer has fixed priority.
// - Sits between VGA timing gen, text RAM, charROM and pixel colour mux.
// PARAMETERS
// - COLS         80  char cells per line
// - ROWS         60  char rows per frame
// - TEXT_AW      13  text RAM address width (COLS*ROWS <= 2**TEXT_AW)
// - BLINK_FRAMES 30  frames per cursor blink half-period
// PORTS
// - clk        in   1        pixel clock; sole clock
// - reset      in   1        synchronous, active-high
// - frame_go   in   1        pulse, start of frame (before first active line)
// - line_go    in   1        pulse, exactly 3 clk before first active pixel of a line
// - text_re    out  1        text RAM read enable
// - text_addr  out  TEXT_AW  text RAM address; data returns next cycle
// - text_data  in   8        char code, valid 1 clk after text_re
// - rom_ce     out  1        charROM ce; rom_oce tied 1 at top level
// - rom_ad     out  11       charROM address
// - rom_dout   in   8        charROM data, valid 1 clk after rom_ce
// - cur_en     in   1        cursor enable
// - cur_col    in   7        cursor column
// - cur_row    in   6        cursor row
// - host_req   in   1        host ROM read request; held high until host_ack
// - host_ad    in   11       host ROM address, stable while host_req
// - host_ack   out  1        1-clk pulse; host_dout valid same cycle
// - host_dout  out  8        host read data, held until next ack
// - pix        out  1        serial pixel, MSB of glyph byte first
// - line_busy  out  1        high from line_go accept until last pixel of line
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; col=0, glyph_row=0, char_row=0, row_base=0, blink_on=1, host pipe empty.
// - FSM: IDLE -(line_go & char_row<ROWS)-> FILL (2 clk) -> RUN -(col==COLS-1 & phase==7)-> IDLE.
// - line_go in FILL/RUN or when char_row==ROWS: ignored. frame_go: any state -> IDLE next clk, pix=0,
//   col/glyph_row/char_row/row_base=0, blink counter advanced; frame_go has priority over same-cycle line_go.
// - Timing from accepted line_go at t0: text_re, text_addr=row_base at t0; rom_ce, rom_ad={text_data,glyph_row} at t0+1;
//   shifter load at t0+2; pix = bit7 at t0+3, bit0 at t0+10. Latency line_go->first pixel = 3 clk.
// - RUN: 3-bit phase, 0 at first pixel of each cell. Next cell (col<COLS-1): text_re at phase 5, rom_ce phase 6,
//   load at phase 7 -> seamless pixels, no gaps.
// - text_addr = row_base + col (no multiplier). End of line: glyph_row++; on wrap 7->0: char_row++, row_base += COLS.
// - Cursor: if cur_en & blink_on & char_row==cur_row & col==cur_col, loaded byte = ~rom_dout.
// - Blink: frame counter 0..BLINK_FRAMES-1; at wrap toggle blink_on.
// - pix=0 whenever not RUN.
// - Arbiter: renderer owns ROM at FILL 2nd clk (t0+1) and RUN phase 6. Any other cycle with host_req and host pipe empty
//   -> grant: rom_ce=1, rom_ad=host_ad at g; capture at g+1; host_ack=1, host_dout at g+2. No new grant until ack.
// - host_req dropped before ack: in-flight read completes, ack still issued. Max host wait 1 clk.
// - Reset mid-line or mid-host-read: abort both; no ack issued.
// STRUCTURE
// - Include file vga_text_defs.vh: COLS, ROWS, CHAR_H=8, state encodings IDLE/FILL/RUN, PREFETCH=3.
// - Sub-module glyph_shifter: 8-bit load/shift register with invert-on-load, pix out.
// - Top holds FSM, counters, arbiter, blink logic.
// TESTING
// - Reset held 4 clk mid-RUN -> next clk pix=0, text_re=0, rom_ce=0, host_ack=0, line_busy=0; next line_go starts at addr 0.
// - Text RAM[0]=0x41, line_go at t0 -> text_addr=0 at t0, rom_ad=0x208 at t0+1, pix t0+3..t0+10 = ROM[0x208] MSB-first.
// - 8 line_go pulses -> 9th line: text_addr first=80, rom_ad low bits=0; 17th line first addr=160.
// - host_req=1, host_ad=0x123 held across line -> no grant at phase 6; host_ack 2 clk after grant, host_dout=ROM[0x123];
//   pix stream bit-identical to no-host run.
// - cur_en=1, cur_col=3, cur_row=0 -> col 3 pixels = ~glyph; after 30 frame_go pulses normal; after 60 inverted again.
// - frame_go mid-RUN with same-cycle line_go -> IDLE, pix=0, line_go ignored; next line_go fetches addr 0, glyph_row 0.

Source files
------------

// File: rtl/glyph_fetch_sched_pkg.sv
// Shared constants, FSM encoding and small helpers for the text-mode glyph fetch scheduler.
package glyph_fetch_sched_pkg;

    localparam int COLS_DEF         = 80;
    localparam int ROWS_DEF         = 60;
    localparam int TEXT_AW_DEF      = 13;
    localparam int BLINK_FRAMES_DEF = 30;
    localparam int CHAR_H           = 8;
    localparam int PREFETCH         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [10:0] glyph_addr(input logic [7:0] code, input logic [2:0] row);
        return {code, row};
    endfunction

    function automatic logic [7:0] cursor_mask(input logic hit);
        return hit ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/glyph_shifter.sv
// 8-bit glyph shift register: parallel load with optional cursor inversion, MSB-first serial out.
module glyph_shifter
    import glyph_fetch_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic       invert,
    input  logic [7:0] din,
    output logic       pix
);

    logic [7:0] sh_r;

    // Load a glyph byte or shift left with zero fill, so the line tail drains to 0
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sh_r <= 8'h00;
        end else if (load) begin
            sh_r <= din ^ cursor_mask(invert);
        end else begin
            sh_r <= {sh_r[6:0], 1'b0};
        end
    end

    assign pix = sh_r[7];

endmodule

// File: rtl/glyph_fetch_sched.sv
// Glyph ROM sequencer for the 80x60 text renderer: fetch FSM, position counters,
// cursor blink and a fixed-priority ROM arbiter with a host read port.
module glyph_fetch_sched
    import glyph_fetch_sched_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int TEXT_AW      = TEXT_AW_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_go,
    input  logic               line_go,
    output logic               text_re,
    output logic [TEXT_AW-1:0] text_addr,
    input  logic [7:0]         text_data,
    output logic               rom_ce,
    output logic [10:0]        rom_ad,
    input  logic [7:0]         rom_dout,
    input  logic               cur_en,
    input  logic [6:0]         cur_col,
    input  logic [5:0]         cur_row,
    input  logic               host_req,
    input  logic [10:0]        host_ad,
    output logic               host_ack,
    output logic [7:0]         host_dout,
    output logic               pix,
    output logic               line_busy
);

    localparam int BW = $clog2(BLINK_FRAMES);

    state_t             state_r, state_nx;
    logic               fill_r;
    logic [2:0]         phase_r;
    logic [6:0]         col_r;
    logic [2:0]         grow_r;
    logic [5:0]         crow_r;
    logic [TEXT_AW-1:0] rbase_r;
    logic [BW-1:0]      bcnt_r;
    logic               blink_r;
    logic               hpend_r, hack_r;
    logic [7:0]         hdout_r;

    logic               accept_s, last_col_s, ren_text_s, ren_rom_s, own_s, load_s, hit_s, grant_s;
    logic [6:0]         ld_col_s;
    logic [TEXT_AW-1:0] text_addr_s;

    assign accept_s   = line_go && (crow_r < 6'(ROWS));
    assign last_col_s = (col_r == 7'(COLS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state and fetch strobes; col_r is the displayed cell, the RUN prefetch targets col_r+1
    always_comb begin
        state_nx    = state_r;
        ren_text_s  = 1'b0;
        ren_rom_s   = 1'b0;
        own_s       = 1'b0;
        load_s      = 1'b0;
        ld_col_s    = col_r;
        text_addr_s = rbase_r;
        if (frame_go) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ren_text_s = 1'b1;
                        state_nx   = ST_FILL;
                    end else begin
                        state_nx   = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (!fill_r) begin
                        ren_rom_s = 1'b1;
                        own_s     = 1'b1;
                    end else begin
                        load_s    = 1'b1;
                        state_nx  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    text_addr_s = rbase_r + TEXT_AW'(col_r) + TEXT_AW'(1'b1);
                    case (phase_r)
                        3'd5: ren_text_s = !last_col_s;
                        3'd6: begin
                            own_s     = 1'b1;
                            ren_rom_s = !last_col_s;
                        end
                        3'd7: begin
                            if (last_col_s) begin
                                state_nx = ST_IDLE;
                            end else begin
                                load_s   = 1'b1;
                                ld_col_s = col_r + 7'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Fill step, pixel phase, column, glyph row, char row and row base
    always_ff @(posedge clk) begin
        if (reset || frame_go) begin
            fill_r  <= 1'b0;
            phase_r <= 3'd0;
            col_r   <= 7'd0;
            grow_r  <= 3'd0;
            crow_r  <= 6'd0;
            rbase_r <= {TEXT_AW{1'b0}};
        end else begin
            fill_r  <= (state_r == ST_FILL) && !fill_r;
            phase_r <= (state_r == ST_RUN) ? phase_r + 3'd1 : 3'd0;
            if ((state_r == ST_RUN) && (phase_r == 3'd7)) begin
                if (last_col_s) begin
                    col_r  <= 7'd0;
                    grow_r <= grow_r + 3'd1;
                    if (grow_r == 3'(CHAR_H - 1)) begin
                        crow_r  <= crow_r + 6'd1;
                        rbase_r <= rbase_r + TEXT_AW'(COLS);
                    end
                end else begin
                    col_r <= col_r + 7'd1;
                end
            end
        end
    end

    // Cursor blink: toggles every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_r  <= {BW{1'b0}};
            blink_r <= 1'b1;
        end else if (frame_go) begin
            if (bcnt_r == BW'(BLINK_FRAMES - 1)) begin
                bcnt_r  <= {BW{1'b0}};
                blink_r <= ~blink_r;
            end else begin
                bcnt_r  <= bcnt_r + BW'(1'b1);
            end
        end
    end

    assign hit_s   = cur_en && blink_r && (crow_r == cur_row) && (ld_col_s == cur_col);
    assign grant_s = host_req && !hpend_r && !hack_r && !own_s;

    // Host read pipe: grant, capture ROM data one cycle later, then ack
    always_ff @(posedge clk) begin
        if (reset) begin
            hpend_r <= 1'b0;
            hack_r  <= 1'b0;
            hdout_r <= 8'h00;
        end else begin
            hpend_r <= grant_s;
            hack_r  <= hpend_r;
            if (hpend_r) begin
                hdout_r <= rom_dout;
            end
        end
    end

    glyph_shifter u_shifter (
        .clk    (clk),
        .reset  (reset),
        .clr    (frame_go),
        .load   (load_s),
        .invert (hit_s),
        .din    (rom_dout),
        .pix    (pix)
    );

    assign text_re   = ren_text_s;
    assign text_addr = text_addr_s;
    assign rom_ce    = ren_rom_s || grant_s;
    assign rom_ad    = ren_rom_s ? glyph_addr(text_data, grow_r) : host_ad;
    assign host_ack  = hack_r;
    assign host_dout = hdout_r;
    assign line_busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// Randomized self-checking bench: text RAM / glyph ROM models plus a per-line pixel reference.
module tb_glyph_fetch_sched;

    logic        clk = 1'b0;
    logic        reset, frame_go, line_go;
    logic        text_re;
    logic [12:0] text_addr;
    logic [7:0]  text_data = 8'h00;
    logic        rom_ce;
    logic [10:0] rom_ad;
    logic [7:0]  rom_dout = 8'h00;
    logic        cur_en;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic        host_req;
    logic [10:0] host_ad;
    logic        host_ack;
    logic [7:0]  host_dout;
    logic        pix, line_busy;

    logic [7:0]  tram [0:8191];
    logic [7:0]  rom  [0:2047];

    int tests = 0;
    int fails = 0;
    int line_idx = 0;
    int frames = 0;
    bit line_done = 1'b0;

    glyph_fetch_sched dut (
        .clk(clk), .reset(reset), .frame_go(frame_go), .line_go(line_go),
        .text_re(text_re), .text_addr(text_addr), .text_data(text_data),
        .rom_ce(rom_ce), .rom_ad(rom_ad), .rom_dout(rom_dout),
        .cur_en(cur_en), .cur_col(cur_col), .cur_row(cur_row),
        .host_req(host_req), .host_ad(host_ad), .host_ack(host_ack), .host_dout(host_dout),
        .pix(pix), .line_busy(line_busy)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle registered reads
    always @(posedge clk) begin
        if (text_re) text_data <= tram[text_addr];
        if (rom_ce)  rom_dout  <= rom[rom_ad];
    end

    // Expected glyph byte for a cell, from line number, text, font and cursor/blink rules
    function automatic logic [7:0] exp_byte(input int li, input int c);
        int          crow;
        logic [10:0] a;
        logic [7:0]  b;
        crow = li / 8;
        a    = {tram[crow * 80 + c], 3'(li % 8)};
        b    = rom[a];
        if (cur_en && ((frames / 30) % 2 == 0) && (crow == int'(cur_row)) && (c == int'(cur_col)))
            b = ~b;
        return b;
    endfunction

    task automatic pulse_frame();
        @(posedge clk); #1; frame_go = 1'b1;
        @(posedge clk); #1; frame_go = 1'b0;
        line_idx = 0;
        frames++;
    endtask

    task automatic run_line();
        int base, g, seq_err;
        logic [639:0] exp_v, got_v;
        logic [7:0] b;
        base = (line_idx / 8) * 80;
        g = line_idx % 8;
        seq_err = 0;
        for (int c = 0; c < 80; c++) begin
            b = exp_byte(line_idx, c);
            for (int k = 0; k < 8; k++) exp_v[639 - (c * 8 + k)] = b[7 - k];
        end
        @(posedge clk); #1; line_go = 1'b1; #3;
        tests++;
        if (text_re !== 1'b1 || text_addr !== 13'(base)) begin
            fails++;
            $display("FAIL line_start line %0d: text_re=%b text_addr=%0d, required 1 and %0d", line_idx, text_re, text_addr, base);
        end
        @(posedge clk); #1; line_go = 1'b0; #3;
        tests++;
        if (rom_ce !== 1'b1 || rom_ad !== {tram[base], 3'(g)}) begin
            fails++;
            $display("FAIL first_rom line %0d: rom_ce=%b rom_ad=%h, required 1 and %h", line_idx, rom_ce, rom_ad, {tram[base], 3'(g)});
        end
        @(posedge clk);
        for (int i = 0; i < 640; i++) begin
            @(posedge clk); #4;
            got_v[639 - i] = pix;
            if (i % 8 == 5 && i / 8 < 79 && (text_re !== 1'b1 || text_addr !== 13'(base + i / 8 + 1))) seq_err++;
            if (i % 8 == 6 && i / 8 < 79 && (rom_ce !== 1'b1 || rom_ad !== {tram[base + i / 8 + 1], 3'(g)})) seq_err++;
            if (line_busy !== 1'b1) seq_err++;
        end
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL pix_stream line %0d: got %h required %h", line_idx, got_v, exp_v);
        end
        tests++;
        if (seq_err !== 0) begin
            fails++;
            $display("FAIL fetch_sequence line %0d: %0d bad cycles, required 0", line_idx, seq_err);
        end
        @(posedge clk); #4;
        tests++;
        if (pix !== 1'b0 || line_busy !== 1'b0) begin
            fails++;
            $display("FAIL line_end line %0d: pix=%b line_busy=%b, required 0 0", line_idx, pix, line_busy);
        end
        line_idx++;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_go = 1'b0; line_go = 1'b0; cur_en = 1'b0;
        cur_col = 7'd0; cur_row = 6'd0; host_req = 1'b0; host_ad = 11'd0;
        repeat (4) @(posedge clk);
        #1; reset = 1'b0; #3;
        tests++;
        if ({pix, text_re, rom_ce, host_ack, line_busy} !== 5'b0 || text_addr !== 13'd0 || host_dout !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: pix/re/ce/ack/busy=%b addr=%0d dout=%h, required all 0",
                     {pix, text_re, rom_ce, host_ack, line_busy}, text_addr, host_dout);
        end
        line_idx = 0;
        frames = 0;
    endtask

    task automatic test_known_char();
        tram[0] = 8'h41;
        test_reset();
        run_line();
    endtask

    task automatic test_rows();
        pulse_frame();
        for (int l = 0; l < 17; l++) run_line();
    endtask

    task automatic host_agent(input bit fixed);
        logic [10:0] a;
        int waitc;
        bit got;
        while (!line_done) begin
            a = fixed ? 11'h123 : 11'($urandom_range(0, 2047));
            @(posedge clk); #1; host_req = 1'b1; host_ad = a;
            got = 1'b0; waitc = 0;
            while (!got && waitc < 6) begin
                @(posedge clk); #4; waitc++;
                if (host_ack === 1'b1) got = 1'b1;
            end
            tests++;
            if (!got || waitc > 3) begin
                fails++;
                $display("FAIL host_latency: ack seen=%0d after %0d clk, required 1 within 3", got, waitc);
            end
            tests++;
            if (host_dout !== rom[a]) begin
                fails++;
                $display("FAIL host_data addr %h: got %h required %h", a, host_dout, rom[a]);
            end
            @(posedge clk); #1; host_req = 1'b0;
        end
    endtask

    task automatic test_host();
        logic [10:0] a;
        int waitc;
        bit got;
        for (int r = 0; r < 2; r++) begin
            pulse_frame();
            line_done = 1'b0;
            fork
                begin run_line(); line_done = 1'b1; end
                host_agent(r == 0);
            join
        end
        a = 11'($urandom_range(0, 2047));
        @(posedge clk); #1; host_req = 1'b1; host_ad = a;
        @(posedge clk); #1; host_req = 1'b0; host_ad = ~a;
        got = 1'b0; waitc = 1;
        while (!got && waitc < 6) begin
            #3; if (host_ack === 1'b1) got = 1'b1;
            if (!got) begin @(posedge clk); #1; waitc++; end
        end
        tests++;
        if (!got || host_dout !== rom[a]) begin
            fails++;
            $display("FAIL host_dropped_req: ack=%0d dout=%h, required 1 and %h", got, host_dout, rom[a]);
        end
    endtask

    task automatic test_cursor();
        test_reset();
        cur_en = 1'b1; cur_col = 7'd3; cur_row = 6'd0;
        run_line();
        repeat (30) pulse_frame();
        run_line();
        repeat (30) pulse_frame();
        run_line();
        cur_col = 7'($urandom_range(0, 79));
        run_line();
        cur_en = 1'b0;
    endtask

    task automatic test_frame_abort();
        pulse_frame();
        run_line();
        @(posedge clk); #1; line_go = 1'b1;
        @(posedge clk); #1; line_go = 1'b0;
        repeat ($urandom_range(10, 600)) @(posedge clk);
        #1; frame_go = 1'b1; line_go = 1'b1; #3;
        tests++;
        if (text_re !== 1'b0) begin
            fails++;
            $display("FAIL abort_line_go: text_re=%b, required 0", text_re);
        end
        @(posedge clk); #1; frame_go = 1'b0; line_go = 1'b0; #3;
        tests++;
        if (pix !== 1'b0 || line_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: pix=%b line_busy=%b, required 0 0", pix, line_busy);
        end
        line_idx = 0;
        frames++;
        run_line();
    endtask

    task automatic test_reset_mid();
        int acks;
        pulse_frame();
        @(posedge clk); #1; line_go = 1'b1;
        @(posedge clk); #1; line_go = 1'b0;
        repeat ($urandom_range(100, 500)) @(posedge clk);
        #1; host_req = 1'b1; host_ad = 11'($urandom_range(0, 2047));
        @(posedge clk); #1; reset = 1'b1; host_req = 1'b0;
        @(posedge clk); #3;
        tests++;
        if ({pix, text_re, rom_ce, host_ack, line_busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_mid_run: pix/re/ce/ack/busy=%b, required 00000", {pix, text_re, rom_ce, host_ack, line_busy});
        end
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        acks = 0;
        repeat (4) begin
            #3; if (host_ack !== 1'b0 || pix !== 1'b0) acks++;
            @(posedge clk); #1;
        end
        tests++;
        if (acks !== 0) begin
            fails++;
            $display("FAIL reset_abort_host: %0d cycles with ack or pix, required 0", acks);
        end
        line_idx = 0;
        frames = 0;
        run_line();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        test_reset();
        test_known_char();
        test_rows();
        test_host();
        test_cursor();
        test_frame_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
